cam_line_pingpong_n: RTL and testbench

//  Camera front-end line buffer: captures data_valid pixel beats, framed by vs, into NUM_BANKS line banks.

---
 rtl/cam_line_pingpong_n.sv | 242 ++++++++++++++++++++++++
 tb/tb_cam_line_pingpong_n.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_line_pingpong_n.sv
// Camera front-end line buffer: captures vs-framed pixel lines into NUM_BANKS banks
// and replays each completed line as a valid/ready stream with row/column tags.
module cam_line_pingpong_n #(
    parameter int DATA_W    = 8,
    parameter int LINE_LEN  = 752,
    parameter int NUM_BANKS = 2,
    parameter int ROWS      = 480,
    localparam int COL_W    = $clog2(LINE_LEN),
    localparam int ROW_W    = $clog2(ROWS),
    localparam int BANK_W   = $clog2(NUM_BANKS),
    localparam int BF_W     = $clog2(NUM_BANKS + 1)
) (
    input  logic              cam_clk,
    input  logic              rst,
    input  logic              en,
    input  logic              vs,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] cam_data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [COL_W-1:0]  out_col,
    output logic [ROW_W-1:0]  out_row,
    output logic              out_last,
    output logic              out_sof,
    output logic              out_eof,
    output logic [BF_W-1:0]   banks_full,
    output logic              overflow,
    output logic [15:0]       drop_cnt,
    output logic [1:0]        dbg_wr_state,
    output logic [1:0]        dbg_rd_state
);

    // Handshake: a beat transfers on every edge where out_valid && out_ready; while
    // out_valid is high and out_ready low, out_data and all tags/flags hold.

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_LEN - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    typedef enum logic [1:0] {W_IDLE, W_LINE, W_DROP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FILL, R_LINE} rd_state_t;

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;

    logic [DATA_W-1:0] mem [NUM_BANKS][LINE_LEN];
    logic [ROW_W-1:0]  bank_row [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_full, full_nxt;
    logic [BF_W-1:0]   full_cnt;

    logic              vs_r, vs_rise, beat;
    logic [COL_W-1:0]  wr_col, wr_col_nxt;
    logic [ROW_W-1:0]  wr_row, wr_row_nxt;
    logic [BANK_W-1:0] wr_bank, wr_bank_nxt;
    logic              rows_done, rows_done_nxt;
    logic              mem_we, line_done, drop_done;

    logic [BANK_W-1:0] rd_bank, rd_bank_nxt;
    logic [COL_W-1:0]  rd_col_sel;
    logic              rd_load, rd_free;

    function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
        return (b == LAST_BANK) ? '0 : b + 1'b1;
    endfunction

    assign vs_rise = vs && !vs_r;
    assign beat    = vs && data_valid;

    assign dbg_wr_state = wr_state;
    assign dbg_rd_state = rd_state;

    always_ff @(posedge cam_clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    // Write side: the decision to store or drop a line is made on its first beat.
    always_comb begin
        wr_state_nxt  = wr_state;
        wr_col_nxt    = wr_col;
        wr_row_nxt    = wr_row;
        wr_bank_nxt   = wr_bank;
        rows_done_nxt = rows_done;
        mem_we        = 1'b0;
        line_done     = 1'b0;
        drop_done     = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (vs_rise) begin
                    wr_state_nxt  = W_LINE;
                    wr_col_nxt    = '0;
                    wr_row_nxt    = '0;
                    rows_done_nxt = 1'b0;
                end
            end
            W_LINE: begin
                if (!vs) begin
                    wr_state_nxt = W_IDLE;
                    wr_col_nxt   = '0;
                end else if (beat && !rows_done) begin
                    if (wr_col == '0 && (bank_full[wr_bank] || !en)) begin
                        wr_state_nxt = W_DROP;
                        wr_col_nxt   = wr_col + 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        if (wr_col == LAST_COL) begin
                            line_done   = 1'b1;
                            wr_col_nxt  = '0;
                            wr_bank_nxt = bank_inc(wr_bank);
                        end else begin
                            wr_col_nxt = wr_col + 1'b1;
                        end
                    end
                end
            end
            W_DROP: begin
                if (!vs) begin
                    wr_state_nxt = W_IDLE;
                    wr_col_nxt   = '0;
                end else if (beat) begin
                    if (wr_col == LAST_COL) begin
                        drop_done    = 1'b1;
                        wr_col_nxt   = '0;
                        wr_state_nxt = W_LINE;
                    end else begin
                        wr_col_nxt = wr_col + 1'b1;
                    end
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
        // Row tag saturates; once the last row is consumed the rest of the frame is ignored.
        if (line_done || drop_done) begin
            if (wr_row == LAST_ROW) rows_done_nxt = 1'b1;
            else                    wr_row_nxt    = wr_row + 1'b1;
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        rd_bank_nxt  = rd_bank;
        rd_load      = 1'b0;
        rd_free      = 1'b0;
        rd_col_sel   = out_col + 1'b1;
        case (rd_state)
            R_IDLE: begin
                if (bank_full[rd_bank]) rd_state_nxt = R_FILL;
            end
            R_FILL: begin
                rd_load      = 1'b1;
                rd_col_sel   = '0;
                rd_state_nxt = R_LINE;
            end
            R_LINE: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        rd_free      = 1'b1;
                        rd_bank_nxt  = bank_inc(rd_bank);
                        rd_state_nxt = bank_full[rd_bank_nxt] ? R_FILL : R_IDLE;
                    end else begin
                        rd_load = 1'b1;
                    end
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        full_nxt = bank_full;
        if (line_done) full_nxt[wr_bank] = 1'b1;
        if (rd_free)   full_nxt[rd_bank] = 1'b0;
        full_cnt = '0;
        for (int i = 0; i < NUM_BANKS; i++) full_cnt = full_cnt + BF_W'(full_nxt[i]);
    end

    always_ff @(posedge cam_clk) begin
        if (mem_we)    mem[wr_bank][wr_col] <= cam_data_in;
        if (line_done) bank_row[wr_bank]    <= wr_row;
    end

    always_ff @(posedge cam_clk) begin
        if (rst) begin
            vs_r       <= 1'b0;
            wr_col     <= '0;
            wr_row     <= '0;
            wr_bank    <= '0;
            rows_done  <= 1'b0;
            rd_bank    <= '0;
            bank_full  <= '0;
            banks_full <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            vs_r       <= vs;
            wr_col     <= wr_col_nxt;
            wr_row     <= wr_row_nxt;
            wr_bank    <= wr_bank_nxt;
            rows_done  <= rows_done_nxt;
            rd_bank    <= rd_bank_nxt;
            bank_full  <= full_nxt;
            banks_full <= full_cnt;
            if (drop_done) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Output register doubles as the RAM read register: one cycle of fill latency.
    always_ff @(posedge cam_clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (rd_load) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_bank][rd_col_sel];
            out_col   <= rd_col_sel;
            out_row   <= bank_row[rd_bank];
            out_last  <= (rd_col_sel == LAST_COL);
            out_sof   <= (bank_row[rd_bank] == '0) && (rd_col_sel == '0);
            out_eof   <= (bank_row[rd_bank] == LAST_ROW) && (rd_col_sel == LAST_COL);
        end else if (rd_free) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cam_line_pingpong_n.sv
// Directed bench for cam_line_pingpong_n: a 2-bank and a 4-bank instance share the
// camera inputs; one of them is observed per test through a transfer monitor.
module tb_cam_line_pingpong_n;

    localparam int DATA_W   = 8;
    localparam int LINE_LEN = 8;
    localparam int ROWS     = 4;

    logic       cam_clk = 1'b0;
    logic       rst = 1'b1, en = 1'b1, vs = 1'b0, data_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] cam_data_in = 8'd0;

    logic       a_valid, a_last, a_sof, a_eof, a_ovf;
    logic [7:0] a_data;
    logic [2:0] a_col;
    logic [1:0] a_row, a_bf, a_ws, a_rs;
    logic [15:0] a_drop;

    logic       b_valid, b_last, b_sof, b_eof, b_ovf;
    logic [7:0] b_data;
    logic [2:0] b_col, b_bf;
    logic [1:0] b_row, b_ws, b_rs;
    logic [15:0] b_drop;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    logic        mon_b = 1'b0;
    logic        rand_ready = 1'b0;
    logic        hold_pend = 1'b0;
    logic [15:0] held = '0;
    logic        obs_valid;
    logic [15:0] obs_rec;

    cam_line_pingpong_n #(.DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .NUM_BANKS(2), .ROWS(ROWS)) dut_a (
        .cam_clk(cam_clk), .rst(rst), .en(en), .vs(vs), .data_valid(data_valid),
        .cam_data_in(cam_data_in), .out_valid(a_valid), .out_ready(out_ready),
        .out_data(a_data), .out_col(a_col), .out_row(a_row), .out_last(a_last),
        .out_sof(a_sof), .out_eof(a_eof), .banks_full(a_bf), .overflow(a_ovf),
        .drop_cnt(a_drop), .dbg_wr_state(a_ws), .dbg_rd_state(a_rs)
    );

    cam_line_pingpong_n #(.DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .NUM_BANKS(4), .ROWS(ROWS)) dut_b (
        .cam_clk(cam_clk), .rst(rst), .en(en), .vs(vs), .data_valid(data_valid),
        .cam_data_in(cam_data_in), .out_valid(b_valid), .out_ready(out_ready),
        .out_data(b_data), .out_col(b_col), .out_row(b_row), .out_last(b_last),
        .out_sof(b_sof), .out_eof(b_eof), .banks_full(b_bf), .overflow(b_ovf),
        .drop_cnt(b_drop), .dbg_wr_state(b_ws), .dbg_rd_state(b_rs)
    );

    always #5 cam_clk = ~cam_clk;

    // Record layout: {row, col, last, sof, eof, data}
    assign obs_valid = mon_b ? b_valid : a_valid;
    assign obs_rec   = mon_b ? {b_row, b_col, b_last, b_sof, b_eof, b_data}
                             : {a_row, a_col, a_last, a_sof, a_eof, a_data};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int row, input int col, input int d);
        logic [1:0] r;
        logic [2:0] c;
        logic [7:0] dd;
        logic l, s, e;
        r  = row[1:0];
        c  = col[2:0];
        dd = d[7:0];
        l  = (col == 7);
        s  = (row == 0 && col == 0);
        e  = (row == 3 && col == 7);
        return {r, c, l, s, e, dd};
    endfunction

    // Transfer monitor plus hold-stability check on the falling edge.
    always @(negedge cam_clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) chk("hold", {15'd0, obs_valid, obs_rec}, {15'd0, 1'b1, held});
            if (obs_valid && out_ready) got_q.push_back(obs_rec);
            hold_pend = obs_valid && !out_ready;
            held      = obs_rec;
        end
    end

    always @(posedge cam_clk) begin
        #2;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge cam_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; vs = 1'b0; data_valid = 1'b0; en = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_line(input int base);
        for (int i = 0; i < LINE_LEN; i++) begin
            data_valid  = 1'b1;
            cam_data_in = 8'(base + i);
            tick();
        end
        data_valid = 1'b0;
    endtask

    task automatic exp_line(input int row, input int base);
        for (int c = 0; c < LINE_LEN; c++) exp_q.push_back(mk(row, c, base + c));
    endtask

    task automatic drain_check(input string tag, input int budget);
        int n;
        int waited;
        n = exp_q.size();
        waited = 0;
        while (got_q.size() < n && waited < budget) begin
            tick();
            waited++;
        end
        repeat (12) tick();
        chk({tag, "_cnt"}, 32'(got_q.size()), 32'(n));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        bit found;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_bf",    32'(a_bf),    32'd0);
        chk("rst_ovf",   32'(a_ovf),   32'd0);
        chk("rst_drop",  32'(a_drop),  32'd0);
        chk("rst_data",  32'(a_data),  32'd0);
        chk("rst_bvalid", 32'(b_valid), 32'd0);

        // 1: four continuous lines 0..31, always ready (4-bank instance keeps up)
        mon_b = 1'b1;
        out_ready = 1'b1;
        vs = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            data_valid  = 1'b1;
            cam_data_in = 8'(i);
            tick();
        end
        data_valid = 1'b0;
        for (int r = 0; r < 4; r++) exp_line(r, r * 8);
        drain_check("t1", 200);
        chk("t1_ovf", 32'(b_ovf), 32'd0);
        vs = 1'b0;
        tick();

        // 2: stalled consumer, third line dropped, then drain rows 0,1
        do_reset();
        mon_b = 1'b0;
        vs = 1'b1;
        tick();
        tick();
        send_line(0);
        send_line(8);
        send_line(16);
        repeat (3) tick();
        chk("t2_bf",          32'(a_bf),    32'd2);
        chk("t2_ovf",         32'(a_ovf),   32'd1);
        chk("t2_drop",        32'(a_drop),  32'd1);
        chk("t2_stall_valid", 32'(a_valid), 32'd1);
        chk("t2_stall_data",  32'(a_data),  32'd0);
        exp_line(0, 0);
        exp_line(1, 8);
        out_ready = 1'b1;
        drain_check("t2", 100);
        chk("t2_bf_after", 32'(a_bf), 32'd0);
        vs = 1'b0;
        tick();

        // 3: vs lost after 5 beats; stray beats with vs low; fresh frame afterwards
        do_reset();
        out_ready = 1'b1;
        vs = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            data_valid  = 1'b1;
            cam_data_in = 8'(100 + i);
            tick();
        end
        data_valid = 1'b0;
        vs = 1'b0;
        tick();
        data_valid  = 1'b1;
        cam_data_in = 8'hEE;
        tick();
        tick();
        data_valid = 1'b0;
        repeat (5) tick();
        chk("t3_bf",    32'(a_bf),          32'd0);
        chk("t3_none",  32'(got_q.size()),  32'd0);
        chk("t3_valid", 32'(a_valid),       32'd0);
        vs = 1'b1;
        tick();
        tick();
        send_line(40);
        exp_line(0, 40);
        drain_check("t3", 60);
        vs = 1'b0;
        tick();

        // 4: random backpressure, 4 banks absorb a full frame
        do_reset();
        mon_b = 1'b1;
        vs = 1'b1;
        tick();
        tick();
        rand_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            data_valid  = 1'b1;
            cam_data_in = 8'(i * 7 + 3);
            tick();
        end
        data_valid = 1'b0;
        for (int i = 0; i < 32; i++) exp_q.push_back(mk(i / 8, i % 8, i * 7 + 3));
        drain_check("t4", 400);
        rand_ready = 1'b0;
        out_ready = 1'b0;
        chk("t4_ovf",  32'(b_ovf),  32'd0);
        chk("t4_drop", 32'(b_drop), 32'd0);
        vs = 1'b0;
        tick();

        // 5: reset mid-readout at column 3 clears overflow and in-flight lines
        do_reset();
        mon_b = 1'b0;
        vs = 1'b1;
        tick();
        tick();
        send_line(60);
        send_line(68);
        send_line(76);
        vs = 1'b0;
        tick();
        tick();
        chk("t5_ovf_pre", 32'(a_ovf), 32'd1);
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (a_valid && a_col == 3'd3) found = 1'b1;
            else tick();
        end
        chk("t5_col3", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", 32'(a_valid), 32'd0);
        chk("t5_bf",    32'(a_bf),    32'd0);
        chk("t5_ovf",   32'(a_ovf),   32'd0);
        chk("t5_drop",  32'(a_drop),  32'd0);
        got_q.delete();
        exp_q.delete();
        tick();
        vs = 1'b1;
        tick();
        tick();
        send_line(90);
        exp_line(0, 90);
        drain_check("t5", 60);
        vs = 1'b0;
        tick();

        // 6: en low for line 1; rows 0,2,3 intact; a fifth line is past ROWS and ignored
        do_reset();
        out_ready = 1'b1;
        vs = 1'b1;
        tick();
        tick();
        send_line(0);
        en = 1'b0;
        send_line(8);
        en = 1'b1;
        send_line(16);
        send_line(24);
        send_line(200);
        exp_line(0, 0);
        exp_line(2, 16);
        exp_line(3, 24);
        drain_check("t6", 150);
        chk("t6_ovf",  32'(a_ovf),  32'd1);
        chk("t6_drop", 32'(a_drop), 32'd1);
        vs = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
